// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - conditional branch resolver with flag register and redirect handshake
module branch_resolver (
    input  logic        clock,
    input  logic        reset,
    input  logic        flag_we,
    input  logic        v_in,
    input  logic        z_in,
    input  logic        c_in,
    input  logic        s_in,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    input  logic [15:0] br_base,
    input  logic [7:0]  br_disp,
    output logic        busy,
    output logic        redirect_valid,
    output logic [15:0] redirect_pc,
    input  logic        redirect_ack,
    output logic [3:0]  flags,
    output logic [15:0] taken_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;
    localparam logic [2:0] COND_B   = 3'b100;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    state_t      state;
    state_t      state_next;

    // Operands captured when the branch is accepted.
    logic [2:0]  cond_q;
    logic [15:0] base_q;
    logic [7:0]  disp_q;

    logic        cond_taken;
    logic [15:0] target;
    logic        accept;
    logic        resolve_taken;
    logic        ack_fire;

    // Flag register fields, ordered {s,z,c,v}.
    logic        flag_s;
    logic        flag_z;
    logic        flag_v;

    assign flag_s = flags[3];
    assign flag_z = flags[2];
    assign flag_v = flags[0];

    // Decode the captured condition code against the current flag register.
    always_comb begin
        cond_taken = 1'b0;
        case (cond_q)
            COND_BE:  cond_taken = flag_z;
            COND_BLT: cond_taken = flag_s ^ flag_v;
            COND_BLE: cond_taken = flag_z | (flag_s ^ flag_v);
            COND_BNE: cond_taken = ~flag_z;
            COND_B:   cond_taken = 1'b1;
            default:  cond_taken = 1'b0;
        endcase
    end

    // Target arithmetic wraps silently at 16 bits.
    assign target = base_q + {{8{disp_q[7]}}, disp_q};

    // Next-state logic and the one-cycle event strobes that drive the datapath.
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        resolve_taken = 1'b0;
        ack_fire      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (br_valid) begin
                    accept     = 1'b1;
                    state_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                resolve_taken = cond_taken;
                state_next    = cond_taken ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                // The ack edge only returns to IDLE; acceptance waits a cycle.
                if (redirect_ack && redirect_valid) begin
                    ack_fire   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; busy is registered alongside it from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
        end
    end

    // Capture branch operands on acceptance; reset discards them.
    always_ff @(posedge clock) begin
        if (reset) begin
            cond_q <= 3'b000;
            base_q <= 16'h0000;
            disp_q <= 8'h00;
        end else if (accept) begin
            cond_q <= br_cond;
            base_q <= br_base;
            disp_q <= br_disp;
        end
    end

    // Flag register loads whenever flag_we is set, regardless of FSM state.
    always_ff @(posedge clock) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (flag_we) begin
            flags <= {s_in, z_in, c_in, v_in};
        end
    end

    // Redirect output: raised on a taken resolution, cleared by the ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 16'h0000;
        end else if (resolve_taken) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
        end else if (ack_fire) begin
            redirect_valid <= 1'b0;
        end
    end

    // Saturating count of taken branches.
    always_ff @(posedge clock) begin
        if (reset) begin
            taken_count <= 16'h0000;
        end else if (resolve_taken && (taken_count != COUNT_MAX)) begin
            taken_count <= taken_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver
module tb_branch_resolver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flag_we = 1'b0;
    logic        v_in = 1'b0;
    logic        z_in = 1'b0;
    logic        c_in = 1'b0;
    logic        s_in = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_cond = 3'b000;
    logic [15:0] br_base = 16'h0000;
    logic [7:0]  br_disp = 8'h00;
    logic        redirect_ack = 1'b0;
    logic        busy;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [3:0]  flags;
    logic [15:0] taken_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [3:0]  m_flags = 4'b0000;
    logic [15:0] m_count = 16'h0000;

    typedef struct {
        logic [15:0] pc;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    bit   prev_rv = 1'b0;

    branch_resolver dut (
        .clock          (clock),
        .reset          (reset),
        .flag_we        (flag_we),
        .v_in           (v_in),
        .z_in           (z_in),
        .c_in           (c_in),
        .s_in           (s_in),
        .br_valid       (br_valid),
        .br_cond        (br_cond),
        .br_base        (br_base),
        .br_disp        (br_disp),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ack   (redirect_ack),
        .flags          (flags),
        .taken_count    (taken_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference rules: flags are {s,z,c,v}.
    function automatic bit model_taken(input logic [2:0] c, input logic [3:0] f);
        bit s, z, v;
        s = f[3];
        z = f[2];
        v = f[0];
        if (c == 3'd0) return z;
        if (c == 3'd1) return s != v;
        if (c == 3'd2) return z || (s != v);
        if (c == 3'd3) return !z;
        if (c == 3'd4) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] model_target(input logic [15:0] base, input logic [7:0] disp);
        int d;
        int t;
        d = (disp >= 8'd128) ? int'(disp) - 256 : int'(disp);
        t = (int'(base) + d + 65536) % 65536;
        return 16'(t);
    endfunction

    // Monitor: every new redirect must match the oldest expectation, pc and arrival cycle.
    always @(negedge clock) begin
        exp_t e;
        if (redirect_valid && !prev_rv) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect actual_pc=%0h required=none", redirect_pc);
            end else begin
                e = exp_q.pop_front();
                check("redirect_pc", 32'(redirect_pc), 32'(e.pc));
                check("redirect_latency", cyc, e.cyc);
            end
        end
        prev_rv = redirect_valid;
    end

    task automatic do_reset();
        reset = 1'b1;
        flag_we = 1'b1;
        {s_in, z_in, c_in, v_in} = 4'($urandom) | 4'b0001;
        br_valid = 1'b1;
        br_cond = 3'b100;
        redirect_ack = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        flag_we = 1'b0;
        br_valid = 1'b0;
        redirect_ack = 1'b0;
        m_flags = 4'b0000;
        m_count = 16'h0000;
        check("rst_busy", busy, 0);
        check("rst_rv", redirect_valid, 0);
        check("rst_pc", redirect_pc, 0);
        check("rst_flags", flags, 0);
        check("rst_count", taken_count, 0);
    endtask

    task automatic idle_cycle(input bit fwe, input logic [3:0] fin, input bit ack);
        br_valid = 1'b0;
        flag_we = fwe;
        {s_in, z_in, c_in, v_in} = fin;
        redirect_ack = ack;
        if (fwe) m_flags = fin;
        @(negedge clock);
        flag_we = 1'b0;
        redirect_ack = 1'b0;
        check("idle_flags", flags, m_flags);
        check("idle_busy", busy, 0);
        check("idle_rv", redirect_valid, 0);
        check("idle_count", taken_count, m_count);
    endtask

    // Issue one branch from IDLE (called right after a falling edge) and follow it to completion.
    task automatic run_branch(input logic [2:0] cond, input logic [15:0] base, input logic [7:0] disp,
                              input bit fwe, input logic [3:0] fin, input int hold,
                              input bit poke, input bit rst_hold);
        bit          tk;
        logic [15:0] tgt;
        exp_t        e;
        br_valid = 1'b1;
        br_cond = cond;
        br_base = base;
        br_disp = disp;
        flag_we = fwe;
        {s_in, z_in, c_in, v_in} = fin;
        redirect_ack = 1'b0;
        if (fwe) m_flags = fin;
        tk = model_taken(cond, m_flags);
        tgt = model_target(base, disp);
        if (tk) begin
            e.pc = tgt;
            e.cyc = cyc + 2;
            exp_q.push_back(e);
        end
        @(negedge clock);
        br_valid = 1'b0;
        flag_we = 1'b0;
        check("eval_busy", busy, 1);
        check("eval_rv", redirect_valid, 0);
        check("eval_flags", flags, m_flags);
        if (tk && m_count != 16'hFFFF) m_count++;
        @(negedge clock);
        check("resolve_busy", busy, tk);
        check("resolve_rv", redirect_valid, tk);
        check("taken_count", taken_count, m_count);
        if (!tk) return;
        for (int i = 0; i < hold; i++) begin
            br_valid = poke;
            br_cond = 3'b100;
            br_base = 16'($urandom);
            br_disp = 8'($urandom);
            @(negedge clock);
            br_valid = 1'b0;
            check("hold_busy", busy, 1);
            check("hold_rv", redirect_valid, 1);
            check("hold_pc", redirect_pc, tgt);
            check("hold_count", taken_count, m_count);
        end
        if (rst_hold) begin
            do_reset();
            return;
        end
        redirect_ack = 1'b1;
        br_valid = poke;
        br_cond = 3'b100;
        @(negedge clock);
        redirect_ack = 1'b0;
        br_valid = 1'b0;
        check("ack_rv", redirect_valid, 0);
        check("ack_busy", busy, 0);
        check("ack_pc_kept", redirect_pc, tgt);
        check("ack_count", taken_count, m_count);
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("init_busy", busy, 0);
        check("init_rv", redirect_valid, 0);
        check("init_pc", redirect_pc, 0);
        check("init_flags", flags, 0);
        check("init_count", taken_count, 0);

        // z=1, then BE 0x0010+5
        idle_cycle(1'b1, 4'b0100, 1'b0);
        run_branch(3'b000, 16'h0010, 8'h05, 1'b0, 4'b0000, 1, 1'b0, 1'b0);
        // BLT using flags written in the acceptance cycle
        run_branch(3'b001, 16'h0100, 8'hFE, 1'b1, 4'b1000, 0, 1'b0, 1'b0);
        // BNE with z=1 and cond 111: not taken; ack while idle ignored
        idle_cycle(1'b1, 4'b0100, 1'b1);
        run_branch(3'b011, 16'h2000, 8'h10, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        run_branch(3'b111, 16'h2000, 8'h10, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        // BLE via z alone
        run_branch(3'b010, 16'h3000, 8'h7F, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        // wrap-around both ways
        run_branch(3'b100, 16'hFFFF, 8'h01, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        run_branch(3'b100, 16'h0000, 8'hFF, 1'b0, 4'b0000, 1, 1'b0, 1'b0);
        // long hold with branch pokes, then immediate re-acceptance
        run_branch(3'b100, 16'h1234, 8'h80, 1'b0, 4'b0000, 5, 1'b1, 1'b0);
        run_branch(3'b100, 16'h4000, 8'h20, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        // reset in HOLD; redirect must not reappear
        run_branch(3'b100, 16'h4321, 8'h10, 1'b1, 4'b1111, 2, 1'b0, 1'b1);
        repeat (3) idle_cycle(1'b0, 4'b0000, 1'b1);
        // reset during EVAL of a taken branch
        br_valid = 1'b1;
        br_cond = 3'b100;
        br_base = 16'h5555;
        br_disp = 8'h01;
        @(negedge clock);
        br_valid = 1'b0;
        check("mid_eval_busy", busy, 1);
        do_reset();
        repeat (3) idle_cycle(1'b0, 4'b0000, 1'b0);

        // randomized mix
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle(1'($urandom), 4'($urandom), 1'($urandom));
            end else begin
                run_branch(3'($urandom), 16'($urandom), 8'($urandom), 1'($urandom),
                           4'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
            end
        end

        // saturation near the top of the counter
        force dut.taken_count = 16'hFFFD;
        #1;
        release dut.taken_count;
        m_count = 16'hFFFD;
        repeat (3) run_branch(3'b100, 16'h0800, 8'h04, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        check("saturated_count", taken_count, 16'hFFFF);

        repeat (3) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 The module SHALL provide the following ports, in this order:
  - clock  input  1  rising-edge clock
  - reset  input  1  synchronous, active-high reset
  - flag_we  input  1  latch the ALU flags this cycle
  - v_in, z_in, c_in, s_in  input  1 each  ALU overflow, zero, carry and sign flags
  - br_valid  input  1  branch issue request
  - br_cond  input  3  condition code
  - br_base  input  16  PC of the branch + 1
  - br_disp  input  8  signed displacement
  - busy  output  1  high when a new branch cannot be accepted
  - redirect_valid  output  1  taken-branch redirect pending
  - redirect_pc  output  16  branch target
  - redirect_ack  input  1  fetch stage accepts the redirect
  - flags  output  4  flag register, ordered {s,z,c,v}
  - taken_count  output  16  count of taken branches
REQ-003 All outputs SHALL be driven from registers.

Function
REQ-004 The flag register SHALL load {s_in,z_in,c_in,v_in} on every rising edge where flag_we=1, in any FSM state, and SHALL otherwise hold its value.
REQ-005 The FSM SHALL have three states: IDLE, EVAL and HOLD. busy SHALL be 0 in IDLE and 1 in EVAL and HOLD.
REQ-006 In IDLE, br_valid=1 SHALL capture br_cond, br_base and br_disp, and the FSM SHALL move to EVAL. While busy=1, br_valid SHALL be ignored.
REQ-007 In EVAL, the condition SHALL be evaluated on the flag register value present during the EVAL cycle. That value includes a flag_we write made on the acceptance edge.
REQ-008 The condition codes SHALL be:
  - 000 BE: taken if z
  - 001 BLT: taken if s^v
  - 010 BLE: taken if z|(s^v)
  - 011 BNE: taken if ~z
  - 100 B: always taken
  - 101-111: never taken
REQ-009 The target SHALL be br_base + sign-extended br_disp, computed modulo 2^16. Wrap-around SHALL be silent: 0xFFFF+1=0x0000 and 0x0000-1=0xFFFF.
REQ-010 On the EVAL edge:
  - if taken, the module SHALL set redirect_valid=1, load redirect_pc and move to HOLD;
  - otherwise it SHALL return to IDLE, and redirect_valid SHALL stay 0.
REQ-011 Latency: redirect_valid SHALL become visible in the cycle after EVAL, i.e. 2 cycles after the br_valid acceptance cycle.
REQ-012 In HOLD, redirect_valid and redirect_pc SHALL remain stable until an edge where redirect_ack=1. On that edge, redirect_valid SHALL clear and the FSM SHALL return to IDLE.
REQ-013 No new branch SHALL be accepted on the ack edge; the earliest next acceptance is the following cycle.
REQ-014 redirect_ack SHALL be ignored while redirect_valid=0.
REQ-015 taken_count SHALL increment on each EVAL edge with a taken result, and SHALL saturate at 0xFFFF.
REQ-016 redirect_pc SHALL hold its last value when redirect_valid=0.

Reset
REQ-017 When reset=1 on a rising edge:
  - state SHALL become IDLE;
  - busy, redirect_valid, redirect_pc, flags and taken_count SHALL all become 0;
  - captured operands SHALL be discarded.
REQ-018 Reset SHALL take priority over flag_we, br_valid and redirect_ack in every state, including mid-EVAL and mid-HOLD.
REQ-019 A pending redirect SHALL be dropped by reset, and SHALL NOT reappear after reset is released.

Verification
REQ-020 Flags z=1 latched, then BE with br_base=0x0010 and br_disp=0x05 -> redirect_valid=1 two cycles later with redirect_pc=0x0015; ack -> redirect_valid=0 and taken_count=1.
REQ-021 flag_we with s=1, v=0 asserted in the same cycle as BLT with br_base=0x0100 and br_disp=0xFE -> taken, redirect_pc=0x00FE (forwarded flags are used).
REQ-022 BNE with z=1 -> not taken; redirect_valid stays 0, busy is high for exactly 1 cycle, taken_count is unchanged; cond=111 behaves the same way.
REQ-023 B with br_base=0xFFFF and br_disp=0x01 -> redirect_pc=0x0000.
REQ-024 Taken branch with redirect_ack held 0 for 5 cycles and a second br_valid asserted during HOLD -> redirect_pc is stable, the second branch is ignored, busy=1; ack -> IDLE, and a new br_valid is accepted the next cycle.
REQ-025 Reset asserted during HOLD -> redirect_valid, flags, taken_count and busy are all 0 on the next cycle. taken_count preloaded to 0xFFFF via repeated taken branches, then one more taken branch -> it stays at 0xFFFF.
